core_mem_arbiter: RTL and testbench
===================================

Name: core_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store data port.
- Accepts one request at a time and grants it with a fixed-priority or round-robin policy.
- Sequences the memory access with a latency counter, returns read data, and pulses an acknowledge to the winner.
- Sits between `core` and the unified memory. It drives the core's `stall_o` while any request is unserved.

Parameters:
- ADDR_WIDTH, 10, word address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- MEM_LATENCY, 1, cycles from the `mem_en_o` cycle to valid `mem_rdata_i`. Must be ≥1; 0 is unsupported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_req_i  in  1  instruction fetch request; held until `if_ack_o`
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_rdata_o  out  DATA_WIDTH  fetched word, valid with `if_ack_o`
- if_ack_o  out  1  one-cycle fetch completion pulse
- d_req_i  in  1  data request; held until `d_ack_o`
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_WIDTH  data address
- d_wdata_i  in  DATA_WIDTH  store data
- d_rdata_o  out  DATA_WIDTH  load data, valid with `d_ack_o`
- d_ack_o  out  1  one-cycle data completion pulse
- mem_en_o  out  1  memory access strobe, one cycle per transaction
- mem_we_o  out  1  memory write enable, qualified by `mem_en_o`
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data
- stall_o  out  1  core stall request

Behaviour:
- Reset values: all registered outputs are 0 (`mem_*`, `*_ack_o`, `*_rdata_o`); state is IDLE; latency counter is 0; last-grant flag selects instruction.
- Reset mid-transaction: the in-flight access is abandoned, no ack is issued, and a late `mem_rdata_i` is ignored.
- States:
  - IDLE: samples the requests.
    - If any request is pending, it latches the winner's address, we and wdata. Next cycle: `mem_en_o`=1 for exactly one cycle, `mem_we_o` = `d_we_i` for a data grant (0 for fetch), then go to WAIT with counter = MEM_LATENCY.
    - No request: all `mem_*` stay 0.
  - WAIT: the counter decrements each cycle.
    - Write: skip the count. Ack in the cycle after `mem_en_o` and return to IDLE.
    - Read: when the counter reaches 0, capture `mem_rdata_i` into the winner's `rdata_o`. Pulse the winner's ack in the following cycle and return to IDLE in that ack cycle.
- Latency, request sampled in IDLE at cycle T:
  - `mem_en_o` at T+1.
  - Read ack at T+2+MEM_LATENCY.
  - Write ack at T+2.
- `rdata_o` holds its value until that port's next read completes. The non-granted port's rdata and ack are unchanged.
- Handshake:
  - A requester holds req and its operands stable until its ack.
  - It deasserts req in the cycle after ack.
  - A req still high in the first IDLE cycle after the ack is treated as a new request.
  - Operand changes while granted are ignored (operands are latched).
- Arbitration happens only in IDLE. A request arriving during WAIT waits and is not lost.
- Default policy: data beats instruction when both are requested in the same cycle.
- `stall_o` is combinational: (`if_req_i` & ~`if_ack_o`) | (`d_req_i` & ~`d_ack_o`).
- Back-to-back: with both requests held, transactions alternate per the policy with no idle gap beyond the IDLE sampling cycle.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A last-grant flag updates on every grant.
  - On simultaneous requests, the port not granted last wins.
  - A single requester always wins regardless of the flag.
- Undefined: fixed data-over-instruction priority; the flag is not implemented.

Test Plan:
- Reset, then idle with no requests → all outputs 0 and `mem_en_o` never asserts over 20 cycles.
- MEM_LATENCY=1; fetch at addr 0x004 with `mem_rdata_i`=0x00500093 → `mem_en_o` at T+1 with `mem_addr_o`=0x004 and `mem_we_o`=0; `if_ack_o` at T+3 with `if_rdata_o`=0x00500093; `stall_o`=1 from T to T+2.
- Store: `d_addr_i`=0x010, `d_wdata_i`=0xDEADBEEF → `mem_en_o`=`mem_we_o`=1 at T+1 with those values; `d_ack_o` at T+2; `d_rdata_o` unchanged.
- Simultaneous fetch 0x008 and load 0x020 → load served first and `d_ack_o` at T+3. Fetch issued at T+4 and `if_ack_o` at T+6. With ARB_ROUND_ROBIN_EN and last grant = data, the fetch goes first.
- MEM_LATENCY=3; load with `rst` asserted in the cycle after `mem_en_o` → no `d_ack_o`, FSM in IDLE, `d_rdata_o`=0; a new fetch afterwards completes normally at T+5.
- A request arriving during WAIT of another port is held → it is served immediately after the first ack; neither ack is dropped or duplicated.

Source files
------------

// File: rtl/core_mem_arbiter_if.sv
// Bus bundle for core_mem_arbiter: fetch port, load/store port and memory side.
// slave = arbiter view, master = core + memory view.
interface core_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic [DATA_WIDTH-1:0] if_rdata_o;
    logic                  if_ack_o;
    logic                  d_req_i;
    logic                  d_we_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic [DATA_WIDTH-1:0] d_rdata_o;
    logic                  d_ack_o;
    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  stall_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_rdata_i,
        output if_rdata_o, if_ack_o,
        output d_rdata_o, d_ack_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output stall_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_rdata_i,
        input  if_rdata_o, if_ack_o,
        input  d_rdata_o, d_ack_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  stall_o
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Fetch/load-store arbiter in front of one single-port synchronous memory.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is data-over-fetch priority.
module core_mem_arbiter #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    core_mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sel_data_q, sel_data_d;
    logic                  wr_q, wr_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  if_ack_q, if_ack_d;
    logic                  d_ack_q, d_ack_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic pend_if, pend_d, pick_data;

    // A port whose ack is on the bus this cycle is not a new request yet.
    assign pend_if = bus.if_req_i & ~if_ack_q;
    assign pend_d  = bus.d_req_i & ~d_ack_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_data_q, last_data_d;
    assign pick_data = pend_d & (~pend_if | ~last_data_q);
`else
    assign pick_data = pend_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_data_d  = sel_data_q;
        wr_d        = wr_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_data_d = last_data_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (pend_if | pend_d) begin
                    state_d    = S_WAIT;
                    cnt_d      = CW'(MEM_LATENCY);
                    sel_data_d = pick_data;
                    wr_d       = pick_data & bus.d_we_i;
                    mem_en_d   = 1'b1;
                    mem_we_d   = pick_data & bus.d_we_i;
                    mem_addr_d = pick_data ? bus.d_addr_i
                                           : bus.if_addr_i;
                    mem_wdata_d = pick_data ? bus.d_wdata_i : '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_data_d = pick_data;
`endif
                end
            end
            S_WAIT: begin
                if (wr_q) begin
                    state_d = S_IDLE;
                    d_ack_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (sel_data_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = bus.mem_rdata_i;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sel_data_q  <= 1'b0;
            wr_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_data_q  <= sel_data_d;
            wr_q        <= wr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q <= last_data_d;
`endif
        end
    end

    assign bus.mem_en_o    = mem_en_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_ack_o    = if_ack_q;
    assign bus.d_ack_o     = d_ack_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.stall_o     = pend_if | pend_d;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: two instances (latency 1 and 3) driven in lockstep.
// Build with +define+ARB_ROUND_ROBIN_EN to check the round-robin variant.
module tb_core_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          preload;
    logic          if_req[2];
    logic          d_req[2];
    logic          d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] rd0, rd1;

    core_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    core_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    core_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .MEM_LATENCY(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    core_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .MEM_LATENCY(3))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus0.if_req_i    = if_req[0];
    assign bus0.if_addr_i   = if_addr;
    assign bus0.d_req_i     = d_req[0];
    assign bus0.d_we_i      = d_we;
    assign bus0.d_addr_i    = d_addr;
    assign bus0.d_wdata_i   = d_wdata;
    assign bus0.mem_rdata_i = rd0;
    assign bus1.if_req_i    = if_req[1];
    assign bus1.if_addr_i   = if_addr;
    assign bus1.d_req_i     = d_req[1];
    assign bus1.d_we_i      = d_we;
    assign bus1.d_addr_i    = d_addr;
    assign bus1.d_wdata_i   = d_wdata;
    assign bus1.mem_rdata_i = rd1;

    logic          iack[2], dack[2], men[2], mwe[2], stl[2];
    logic [AW-1:0] maddr[2];
    logic [DW-1:0] mwd[2], ird[2], drd[2];
    assign iack[0] = bus0.if_ack_o;    assign iack[1] = bus1.if_ack_o;
    assign dack[0] = bus0.d_ack_o;     assign dack[1] = bus1.d_ack_o;
    assign men[0] = bus0.mem_en_o;     assign men[1] = bus1.mem_en_o;
    assign mwe[0] = bus0.mem_we_o;     assign mwe[1] = bus1.mem_we_o;
    assign stl[0] = bus0.stall_o;      assign stl[1] = bus1.stall_o;
    assign maddr[0] = bus0.mem_addr_o; assign maddr[1] = bus1.mem_addr_o;
    assign mwd[0] = bus0.mem_wdata_o;  assign mwd[1] = bus1.mem_wdata_o;
    assign ird[0] = bus0.if_rdata_o;   assign ird[1] = bus1.if_rdata_o;
    assign drd[0] = bus0.d_rdata_o;    assign drd[1] = bus1.d_rdata_o;

    // Memory models: read data is valid only in the cycle LAT after mem_en.
    logic [DW-1:0] mem0 [0:1023];
    logic [DW-1:0] mem1 [0:1023];
    int            vc0 = 0, vc1 = 0;
    logic [AW-1:0] va0, va1;

    always @(posedge clk) begin
        if (preload) begin
            mem0[10'h004] <= 32'h00500093;
            mem0[10'h008] <= 32'h00A00113;
            mem0[10'h020] <= 32'h12345678;
            mem0[10'h3FF] <= 32'hCAFEF00D;
        end else if (men[0] && mwe[0]) begin
            mem0[maddr[0]] <= mwd[0];
        end
        if (men[0] && !mwe[0]) begin
            vc0 <= 1;
            va0 <= maddr[0];
        end else if (vc0 != 0) begin
            vc0 <= vc0 - 1;
        end
    end

    always @(posedge clk) begin
        if (preload) begin
            mem1[10'h004] <= 32'h00500093;
            mem1[10'h008] <= 32'h00A00113;
            mem1[10'h020] <= 32'h12345678;
            mem1[10'h3FF] <= 32'hCAFEF00D;
        end else if (men[1] && mwe[1]) begin
            mem1[maddr[1]] <= mwd[1];
        end
        if (men[1] && !mwe[1]) begin
            vc1 <= 3;
            va1 <= maddr[1];
        end else if (vc1 != 0) begin
            vc1 <= vc1 - 1;
        end
    end

    assign rd0 = (vc0 == 1) ? mem0[va0] : 32'hBAD0BAD0;
    assign rd1 = (vc1 == 1) ? mem1[va1] : 32'hBAD1BAD1;

    typedef struct {
        bit            is_d;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    int checks = 0;
    int failures = 0;

    int            t_i[2], t_d[2], n_i[2], n_d[2], ne[2];
    int            en_t[2][4];
    logic [AW-1:0] en_a[2][4];
    logic          en_w[2][4];
    logic [DW-1:0] en_wd[2][4];
    logic [63:0]   st[2];
    logic [DW-1:0] exp_ird[2], exp_drd[2];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input int k,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s [lat%0d] got=%0h exp=%0h",
                     nm, lat(k), got, exp);
        end
    endtask

    // Cycle c=0 is the first cycle a request is visible; each
    // requester drops req in the cycle after its ack.
    task automatic run_seq(input int i_at, input int d_at,
                           input int rst_at, input int budget);
        bit gi[2], gd[2];
        for (int k = 0; k < 2; k++) begin
            t_i[k] = -1; t_d[k] = -1;
            n_i[k] = 0;  n_d[k] = 0; ne[k] = 0;
            st[k] = '0;
            for (int j = 0; j < 4; j++) en_t[k][j] = -1;
        end
        for (int c = 0; c < budget; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (c == i_at) if_req[k] = 1'b1;
                if (c == d_at) d_req[k] = 1'b1;
                if (c == rst_at) begin
                    if_req[k] = 1'b0;
                    d_req[k] = 1'b0;
                end
            end
            if (c == rst_at) rst = 1'b1;
            else if (rst_at >= 0 && c == rst_at + 1) rst = 1'b0;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                gi[k] = iack[k];
                gd[k] = dack[k];
                if (gi[k]) begin
                    n_i[k]++;
                    if (t_i[k] < 0) t_i[k] = c;
                end
                if (gd[k]) begin
                    n_d[k]++;
                    if (t_d[k] < 0) t_d[k] = c;
                end
                if (men[k]) begin
                    if (ne[k] < 4) begin
                        en_t[k][ne[k]] = c;
                        en_a[k][ne[k]] = maddr[k];
                        en_w[k][ne[k]] = mwe[k];
                        en_wd[k][ne[k]] = mwd[k];
                    end
                    ne[k]++;
                end
                if (c < 64) st[k][c] = stl[k];
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (gi[k]) if_req[k] = 1'b0;
                if (gd[k]) d_req[k] = 1'b0;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int ea;
        if (v.is_d) begin
            d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
            if_addr = ~v.addr;
            run_seq(-1, 0, -1, 10);
        end else begin
            if_addr = v.addr;
            d_we = 1'b1; d_addr = ~v.addr; d_wdata = 32'h5555AAAA;
            run_seq(0, -1, -1, 10);
        end
        for (int k = 0; k < 2; k++) begin
            ea = v.we ? 2 : 2 + lat(k);
            chk("en_count", k, 64'(ne[k]), 1);
            chk("en_cycle", k, 64'(en_t[k][0]), 1);
            chk("mem_addr", k, 64'(en_a[k][0]), 64'(v.addr));
            chk("mem_we", k, 64'(en_w[k][0]), 64'(v.we));
            if (v.we)
                chk("mem_wdata", k, 64'(en_wd[k][0]), 64'(v.wdata));
            if (v.is_d) begin
                chk("d_ack_cycle", k, 64'(t_d[k]), 64'(ea));
                chk("d_ack_count", k, 64'(n_d[k]), 1);
                chk("if_ack_count", k, 64'(n_i[k]), 0);
                if (!v.we) exp_drd[k] = v.exp_rdata;
            end else begin
                chk("if_ack_cycle", k, 64'(t_i[k]), 64'(ea));
                chk("if_ack_count", k, 64'(n_i[k]), 1);
                chk("d_ack_count", k, 64'(n_d[k]), 0);
                exp_ird[k] = v.exp_rdata;
            end
            chk("stall_req", k, 64'(st[k][0]), 1);
            chk("stall_pre_ack", k, 64'(st[k][ea-1]), 1);
            chk("stall_at_ack", k, 64'(st[k][ea]), 0);
            chk("if_rdata", k, 64'(ird[k]), 64'(exp_ird[k]));
            chk("d_rdata", k, 64'(drd[k]), 64'(exp_drd[k]));
        end
    endtask

    vec_t vt[8];
    bit   fetch_first;

    initial begin
        vt[0] = '{0, 0, 10'h004, 32'h0,        32'h00500093};
        vt[1] = '{1, 1, 10'h010, 32'hDEADBEEF, 32'h0};
        vt[2] = '{1, 0, 10'h010, 32'h0,        32'hDEADBEEF};
        vt[3] = '{0, 0, 10'h3FF, 32'h0,        32'hCAFEF00D};
        vt[4] = '{1, 1, 10'h000, 32'hFFFFFFFF, 32'h0};
        vt[5] = '{1, 0, 10'h000, 32'h0,        32'hFFFFFFFF};
        vt[6] = '{0, 0, 10'h000, 32'h0,        32'hFFFFFFFF};
        vt[7] = '{1, 0, 10'h004, 32'h0,        32'h00500093};

        rst = 1'b1; preload = 1'b1;
        d_we = 1'b0; if_addr = '0; d_addr = '0; d_wdata = '0;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; d_req[k] = 1'b0;
            exp_ird[k] = '0; exp_drd[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; preload = 1'b0;

        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_mem_en", k, 64'(men[k]), 0);
            chk("rst_mem_we", k, 64'(mwe[k]), 0);
            chk("rst_mem_addr", k, 64'(maddr[k]), 0);
            chk("rst_mem_wdata", k, 64'(mwd[k]), 0);
            chk("rst_acks", k, 64'({iack[k], dack[k]}), 0);
            chk("rst_rdata", k, {ird[k], drd[k]}, 0);
            chk("rst_stall", k, 64'(stl[k]), 0);
        end
        @(posedge clk);
        #1;

        run_seq(-1, -1, -1, 20);
        for (int k = 0; k < 2; k++) begin
            chk("idle_en_count", k, 64'(ne[k]), 0);
            chk("idle_acks", k, 64'(n_i[k] + n_d[k]), 0);
            chk("idle_stall", k, st[k], 0);
        end

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // Both ports at once; the last grant above went to data.
`ifdef ARB_ROUND_ROBIN_EN
        fetch_first = 1'b1;
`else
        fetch_first = 1'b0;
`endif
        if_addr = 10'h008; d_addr = 10'h020; d_we = 1'b0;
        run_seq(0, 0, -1, 16);
        for (int k = 0; k < 2; k++) begin
            chk("sim_en_count", k, 64'(ne[k]), 2);
            chk("sim_en0_cycle", k, 64'(en_t[k][0]), 1);
            chk("sim_en1_cycle", k, 64'(en_t[k][1]), 64'(3 + lat(k)));
            chk("sim_en0_addr", k, 64'(en_a[k][0]),
                fetch_first ? 64'h008 : 64'h020);
            chk("sim_en1_addr", k, 64'(en_a[k][1]),
                fetch_first ? 64'h020 : 64'h008);
            chk("sim_if_ack", k, 64'(t_i[k]),
                64'(fetch_first ? 2 + lat(k) : 4 + 2 * lat(k)));
            chk("sim_d_ack", k, 64'(t_d[k]),
                64'(fetch_first ? 4 + 2 * lat(k) : 2 + lat(k)));
            chk("sim_ack_counts", k, 64'(n_i[k] * 4 + n_d[k]), 5);
            chk("sim_if_rdata", k, 64'(ird[k]), 64'h00A00113);
            chk("sim_d_rdata", k, 64'(drd[k]), 64'h12345678);
        end

        // Load request arrives while the fetch is in WAIT.
        if_addr = 10'h3FF; d_addr = 10'h010; d_we = 1'b0;
        run_seq(0, 2, -1, 16);
        for (int k = 0; k < 2; k++) begin
            chk("late_en_count", k, 64'(ne[k]), 2);
            chk("late_en1_addr", k, 64'(en_a[k][1]), 64'h010);
            chk("late_if_ack", k, 64'(t_i[k]), 64'(2 + lat(k)));
            chk("late_d_ack", k, 64'(t_d[k]), 64'(4 + 2 * lat(k)));
            chk("late_ack_counts", k, 64'(n_i[k] * 4 + n_d[k]), 5);
            chk("late_if_rdata", k, 64'(ird[k]), 64'hCAFEF00D);
            chk("late_d_rdata", k, 64'(drd[k]), 64'hDEADBEEF);
        end

        // Reset asserted in the cycle after mem_en of a load.
        d_addr = 10'h020; d_we = 1'b0;
        run_seq(-1, 0, 2, 12);
        for (int k = 0; k < 2; k++) begin
            chk("abort_en_count", k, 64'(ne[k]), 1);
            chk("abort_acks", k, 64'(n_i[k] + n_d[k]), 0);
            chk("abort_d_rdata", k, 64'(drd[k]), 0);
            chk("abort_if_rdata", k, 64'(ird[k]), 0);
            exp_ird[k] = '0; exp_drd[k] = '0;
        end
        run_vec(vt[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
